// File: rtl/conv_8x32_pkg.sv
// Shared definitions for the conv_8x32 match controller.
//   DEF_DATA_WIDTH : default element/key width
//   DEF_NUM_ELEM   : default number of buffer entries scanned per run
//   state_e        : scan sequencer states
package conv_8x32_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_ELEM   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/conv_8x32_match_ctrl_comp_eq.sv
// Equality comparator shared by every entry of a scan.
//   a_i  : buffer element
//   b_i  : latched search key
//   eq_o : 1 when a_i equals b_i
module conv_8x32_comp_eq #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  eq_o
);

  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/conv_8x32_match_ctrl.sv
// Scan sequencer: walks a NUM_ELEM-entry buffer through a synchronous-read
// port, compares every element against a latched key with one shared
// comparator, and reports a match bitmap, match count and first match index.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, abort      : launch a scan (IDLE only) / cancel a running scan
//   key               : search key, latched on an accepted start
//   rd_en, rd_addr    : buffer read request (data returns one cycle later)
//   rd_data           : buffer read data
//   busy, done        : scan in progress / one-cycle completion pulse
//   result_valid      : results valid until the next accepted start
//   match_map, match_cnt, found, first_idx : scan results
//
// Optional build macro CONV_MATCH_EARLY_STOP_EN: stop the scan at the first
// match instead of always scanning the whole buffer.
module conv_8x32_match_ctrl
  import conv_8x32_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int NUM_ELEM   = DEF_NUM_ELEM,
  localparam int ADDR_WIDTH = $clog2(NUM_ELEM),
  localparam int CNT_WIDTH  = $clog2(NUM_ELEM + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] key,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  result_valid,
  output logic [NUM_ELEM-1:0]   match_map,
  output logic [CNT_WIDTH-1:0]  match_cnt,
  output logic                  found,
  output logic [ADDR_WIDTH-1:0] first_idx
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_ELEM - 1);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   key_q, key_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  // pend_q/pend_idx_q tag the read whose data is on rd_data this cycle
  logic                    pend_q, pend_d;
  logic [ADDR_WIDTH-1:0]   pend_idx_q, pend_idx_d;
  logic [NUM_ELEM-1:0]     map_q, map_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    found_q, found_d;
  logic [ADDR_WIDTH-1:0]   first_q, first_d;
  logic                    done_q, done_d;
  logic                    rv_q, rv_d;
  logic                    eq_s;
  logic                    hit_s;
  logic                    start_ok_s;

  conv_8x32_comp_eq #(.DATA_WIDTH(DATA_WIDTH)) u_comp_eq (
    .a_i  (rd_data),
    .b_i  (key_q),
    .eq_o (eq_s)
  );

  assign hit_s = pend_q & eq_s;
  // A start in the done cycle is dropped so the result pulse is never masked.
  assign start_ok_s = start & ~abort & ~done_q;

  // Next-state, address sequencing and result accumulation.
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    addr_d     = addr_q;
    pend_d     = 1'b0;
    pend_idx_d = pend_idx_q;
    map_d      = map_q;
    cnt_d      = cnt_q;
    found_d    = found_q;
    first_d    = first_q;
    done_d     = 1'b0;
    rv_d       = rv_q;

    case (state_q)
      IDLE: begin
        if (start_ok_s) begin
          state_d = RUN;
          key_d   = key;
          addr_d  = '0;
          map_d   = '0;
          cnt_d   = '0;
          found_d = 1'b0;
          first_d = '0;
          rv_d    = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        pend_d     = 1'b1;
        pend_idx_d = addr_q;
        if (addr_q == LAST_ADDR) begin
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
        rv_d    = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (hit_s) begin
      map_d[pend_idx_q] = 1'b1;
      cnt_d             = cnt_q + CNT_WIDTH'(1);
      if (!found_q) begin
        found_d = 1'b1;
        first_d = pend_idx_q;
      end else begin
        found_d = found_q;
      end
`ifdef CONV_MATCH_EARLY_STOP_EN
      // Finish at the first hit; the read issued this cycle is dropped.
      state_d = IDLE;
      done_d  = 1'b1;
      rv_d    = 1'b1;
      pend_d  = 1'b0;
`endif
    end else begin
      cnt_d = cnt_d;
    end

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      done_d  = 1'b0;
      rv_d    = 1'b0;
      pend_d  = 1'b0;
    end else begin
      rv_d = rv_d;
    end

    // Address parks at zero whenever no read is being issued.
    if (state_d != RUN) begin
      addr_d = '0;
    end else begin
      addr_d = addr_d;
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      key_q      <= '0;
      addr_q     <= '0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      map_q      <= '0;
      cnt_q      <= '0;
      found_q    <= 1'b0;
      first_q    <= '0;
      done_q     <= 1'b0;
      rv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      addr_q     <= addr_d;
      pend_q     <= pend_d;
      pend_idx_q <= pend_idx_d;
      map_q      <= map_d;
      cnt_q      <= cnt_d;
      found_q    <= found_d;
      first_q    <= first_d;
      done_q     <= done_d;
      rv_q       <= rv_d;
    end
  end

  assign rd_en        = (state_q == RUN);
  assign rd_addr      = addr_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign result_valid = rv_q;
  assign match_map    = map_q;
  assign match_cnt    = cnt_q;
  assign found        = found_q;
  assign first_idx    = first_q;

endmodule

// File: tb/tb_conv_8x32_match_ctrl.sv
module tb_conv_8x32_match_ctrl;

  localparam int NE = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  key = 8'h00;
  logic [4:0]  rd_addr;
  logic        rd_en;
  logic [7:0]  rd_data = 8'h00;
  logic        busy, done, result_valid, found;
  logic [31:0] match_map;
  logic [5:0]  match_cnt;
  logic [4:0]  first_idx;

  logic [7:0]  mem [NE];
  int          vec_cnt = 0;
  int          err_cnt = 0;

  conv_8x32_match_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .key(key),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .busy(busy),
    .done(done), .result_valid(result_valid), .match_map(match_map),
    .match_cnt(match_cnt), .found(found), .first_idx(first_idx)
  );

  always #5 clk = ~clk;

  // Buffer model: synchronous read, one cycle latency.
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference results derived from the buffer contents and the key.
  logic [31:0] e_map;
  int          e_cnt, e_first, e_lat;
  logic        e_found;

  task automatic model(input logic [7:0] k);
    e_map = 32'h0; e_cnt = 0; e_found = 1'b0; e_first = 0;
    for (int i = 0; i < NE; i++) begin
      if (mem[i] == k) begin
        if (!e_found) begin e_found = 1'b1; e_first = i; end
        e_map[i] = 1'b1;
        e_cnt++;
      end
    end
    e_lat = NE + 1;
`ifdef CONV_MATCH_EARLY_STOP_EN
    if (e_found) begin
      e_map = 32'h0;
      e_map[e_first] = 1'b1;
      e_cnt = 1;
      e_lat = e_first + 2;
    end
`endif
  endtask

  // Launch a scan; optional second start (ignored) and optional abort cycle.
  task automatic run_scan(input string tag, input logic [7:0] k,
                          input int start2_at, input logic [7:0] k2, input int abort_at);
    int cyc;
    int busy_gap;
    logic got_done;
    model(k);
    cyc = 0; busy_gap = 0; got_done = 1'b0;
    @(negedge clk); start = 1'b1; key = k;
    @(posedge clk); #1; start = 1'b0;
    while (cyc < 60 && !got_done) begin
      @(negedge clk);
      start = (cyc + 1 == start2_at);
      if (start) key = k2;
      abort = (cyc + 1 == abort_at);
      @(posedge clk); #1;
      cyc++;
      start = 1'b0; abort = 1'b0;
      if (cyc == abort_at) begin
        chk({tag, "_abort_busy"}, 64'(busy), 64'd0);
        chk({tag, "_abort_done"}, 64'(done), 64'd0);
        chk({tag, "_abort_rv"}, 64'(result_valid), 64'd0);
        for (int j = 0; j < 40; j++) begin
          @(posedge clk); #1;
          if (done || busy) got_done = 1'b1;
        end
        chk({tag, "_abort_quiet"}, 64'(got_done), 64'd0);
        return;
      end
      if (done) got_done = 1'b1;
      else if (!busy) busy_gap++;
    end
    chk({tag, "_timeout"}, 64'(got_done), 64'd1);
    chk({tag, "_latency"}, 64'(cyc), 64'(e_lat));
    chk({tag, "_map"}, 64'(match_map), 64'(e_map));
    chk({tag, "_cnt"}, 64'(match_cnt), 64'(e_cnt));
    chk({tag, "_found"}, 64'(found), 64'(e_found));
    chk({tag, "_first"}, 64'(first_idx), 64'(e_first));
    chk({tag, "_rv"}, 64'(result_valid), 64'd1);
    chk({tag, "_busy_end"}, 64'(busy), 64'd0);
    chk({tag, "_busy_gap"}, 64'(busy_gap), 64'd0);
    // Start in the done cycle must be ignored.
    @(negedge clk); start = 1'b1; key = ~k;
    @(posedge clk); #1; start = 1'b0;
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_start_in_done"}, 64'(busy), 64'd0);
    chk({tag, "_rv_hold"}, 64'(result_valid), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < NE; i++) mem[i] = 8'h00;
    #1;
    chk("reset_outs", {rd_en, rd_addr, busy, done, result_valid, match_map,
                       match_cnt, found, first_idx}, 64'd0);
    #20 rst_n = 1'b1;

    // All entries match.
    for (int i = 0; i < NE; i++) mem[i] = 8'hA5;
    run_scan("all_match", 8'hA5, 0, 8'h00, 0);

    // Only the last entry matches.
    for (int i = 0; i < NE; i++) mem[i] = 8'h11;
    mem[31] = 8'h3C;
    run_scan("last_only", 8'h3C, 0, 8'h00, 0);

    // No match.
    run_scan("no_match", 8'h00, 0, 8'h00, 0);

    // Entries 4, 9, 20 match; a second start mid-scan is ignored.
    mem[31] = 8'h11;
    mem[4] = 8'h77; mem[9] = 8'h77; mem[20] = 8'h77; mem[12] = 8'h11;
    run_scan("three_ign", 8'h77, 10, 8'h11, 0);

    // Abort at cycle 15, then a clean full scan.
    run_scan("abort", 8'h77, 0, 8'h00, 15);
    run_scan("after_abort", 8'h77, 0, 8'h00, 0);

    // Abort together with start in IDLE: nothing starts.
    @(negedge clk); start = 1'b1; abort = 1'b1; key = 8'h77;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    chk("abort_start_idle", 64'(busy), 64'd0);

    // Reset in the middle of a scan.
    @(negedge clk); start = 1'b1; key = 8'h77;
    @(posedge clk); #1; start = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midscan_reset", {rd_en, rd_addr, busy, done, result_valid, match_map,
                          match_cnt, found, first_idx}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    run_scan("after_reset", 8'h77, 0, 8'h00, 0);

    // Randomized buffers and keys.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NE; i++) mem[i] = 8'(8'h10 * $urandom_range(1, 4));
      run_scan("rand", 8'(8'h10 * $urandom_range(1, 5)), 0, 8'h00, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
